// File: rtl/cisc_pkg.sv
// Shared types for the CISC core memory subsystem.
// Width defaults, requester ID and arbiter FSM states.
package cisc_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 16;

  typedef logic req_id_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAITST,
    DONE
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational round-robin pick between two requesters.
// Ports: req vector, last winner in; valid, winner out.
module mem_arb_pick
  import cisc_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic       valid,
  output req_id_t    winner
);

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    valid  = |req;
    winner = (&req) ? ~last : req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the shared data memory.
// Ports: req/we/lock/addr/wdata per requester, gnt/ack/rdata back, mem_* port.
module mem_arbiter
  import cisc_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int WAIT     = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] WAIT_L = 3'(WAIT);
  localparam logic [3:0] HOLD_L = 4'(MAX_HOLD);

  arb_state_t    state;
  req_id_t       last;
  req_id_t       owner;
  logic [3:0]    hold_cnt;
  logic [2:0]    wcnt;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic          pick_valid;
  req_id_t       pick_win;

  req_id_t       sel;
  logic          sel_req;
  logic          sel_lock;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          cont;

  mem_arb_pick u_pick (
    .req    ({req1, req0}),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_win)
  );

  // Fresh winner in IDLE, current owner for a locked continuation.
  always_comb begin
    sel       = (state == IDLE) ? pick_win : owner;
    sel_req   = sel ? req1   : req0;
    sel_lock  = sel ? lock1  : lock0;
    sel_we    = sel ? we1    : we0;
    sel_addr  = sel ? addr1  : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    cont      = sel_req & sel_lock & (hold_cnt < HOLD_L);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      hold_cnt  <= 4'd1;
      wcnt      <= 3'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata  <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_win;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            gnt0      <= ~pick_win;
            gnt1      <= pick_win;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en    <= 1'b1;
          mem_we    <= lat_we;
          mem_addr  <= lat_addr;
          mem_wdata <= lat_wdata;
          wcnt      <= WAIT_L;
          state     <= (WAIT == 0) ? DONE : WAITST;
        end
        WAITST: begin
          wcnt <= wcnt - 3'd1;
          if (wcnt <= 3'd1) state <= DONE;
        end
        DONE: begin
          ack0  <= ~owner;
          ack1  <= owner;
          rdata <= lat_we ? '0 : mem_rdata;
          last  <= owner;
          if (cont) begin
            hold_cnt  <= hold_cnt + 4'd1;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            state     <= ACCESS;
          end else begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            hold_cnt <= 4'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
